// File: rtl/il1_fill_pkg.sv
// ----------------------------------------------------------------------------
// il1_fill_pkg
// Shared types and default sizes for the IL1 miss-handling / line-fill
// sequencer and its optional bus timer.
//
// Contents:
//   fill_state_e        - sequencer states (IDLE, REQ, ISSUE, WAIT, FILL, DONE)
//   IL1_ADDR_W          - default address width
//   IL1_DATA_W          - default common data bus width
//   IL1_WAY_W           - default way index width (4-way cache)
//   IL1_TIMEOUT_CYCLES  - default WAIT-state limit (only used when the
//                         IL1_FILL_TIMEOUT_EN macro is defined)
// ----------------------------------------------------------------------------
package il1_fill_pkg;

    localparam int IL1_ADDR_W         = 32;
    localparam int IL1_DATA_W         = 32;
    localparam int IL1_WAY_W          = 2;
    localparam int IL1_TIMEOUT_CYCLES = 255;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        FILL  = 3'd4,
        DONE  = 3'd5
    } fill_state_e;

endpackage : il1_fill_pkg

// File: rtl/il1_fill_controller_bus_timer.sv
// ----------------------------------------------------------------------------
// il1_bus_timer
// 8-bit WAIT-cycle counter used to detect a bus read that never returns data.
// Only instantiated when the IL1_FILL_TIMEOUT_EN macro is defined.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   clear_i    in   restart the count (asserted while a BusRd is issued)
//   enable_i   in   count this cycle (asserted while waiting for data)
//   expired_o  out  high during the LIMIT-th enabled cycle since clear
// ----------------------------------------------------------------------------
module il1_bus_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    logic [7:0] count_q;

    // The count holds the number of enabled cycles already completed, so the
    // n-th enabled cycle sees n-1 and the limit is hit at LIMIT-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else if (clear_i) begin
            count_q <= 8'd0;
        end else if (enable_i) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign expired_o = enable_i && (count_q == 8'(LIMIT - 1));

endmodule : il1_bus_timer

// File: rtl/il1_fill_controller.sv
// ----------------------------------------------------------------------------
// il1_fill_controller
// Miss-handling and line-fill sequencer for one processor's IL1 instruction
// cache. Hits are reported straight back as Blk_accessed; misses latch the
// pseudo-LRU victim, arbitrate for the instruction snoop bus, issue a BusRd,
// write the returned line into the victim way and then report that way.
//
// Optional feature: define IL1_FILL_TIMEOUT_EN to build a WAIT-state timeout
// that pulses Fill_err and re-issues the BusRd. Without it Fill_err is 0 and
// WAIT waits indefinitely.
//
// Ports:
//   clk, rst_n            clock / asynchronous active-low reset
//   PrRd, Address         processor read request and address
//   Hit, Hit_way          tag match result from the IL1 array
//   LRU_replacement_proc  victim way from cache_controller_I_1
//   CPU_stall             processor must hold its request
//   Bus_req, Bus_grant    snoop-bus arbitration
//   BusRd                 one-cycle bus read command
//   Address_Com_out       address on the common bus (valid with BusRd)
//   Data_Bus_Com          returned line data
//   Data_valid_Com        Data_Bus_Com valid this cycle
//   Fill_en               one-cycle write strobe into the IL1 array
//   Fill_way/addr/data    write way, line address and data
//   Blk_accessed          accessed way, to cache_controller_I_1
//   Blk_access_valid      one-cycle qualifier for Blk_accessed
//   Fill_err              timeout pulse
// ----------------------------------------------------------------------------
module il1_fill_controller
    import il1_fill_pkg::*;
#(
    parameter int ADDR_W         = IL1_ADDR_W,
    parameter int DATA_W         = IL1_DATA_W,
    parameter int WAY_W          = IL1_WAY_W,
    parameter int TIMEOUT_CYCLES = IL1_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              PrRd,
    input  logic [ADDR_W-1:0] Address,
    input  logic              Hit,
    input  logic [WAY_W-1:0]  Hit_way,
    input  logic [WAY_W-1:0]  LRU_replacement_proc,
    output logic              CPU_stall,
    output logic              Bus_req,
    input  logic              Bus_grant,
    output logic              BusRd,
    output logic [ADDR_W-1:0] Address_Com_out,
    input  logic [DATA_W-1:0] Data_Bus_Com,
    input  logic              Data_valid_Com,
    output logic              Fill_en,
    output logic [WAY_W-1:0]  Fill_way,
    output logic [ADDR_W-1:0] Fill_addr,
    output logic [DATA_W-1:0] Fill_data,
    output logic [WAY_W-1:0]  Blk_accessed,
    output logic              Blk_access_valid,
    output logic              Fill_err
);

    fill_state_e       state_q, state_d;
    logic [ADDR_W-1:0] missAddr_q;
    logic [WAY_W-1:0]  victimWay_q;
    logic [DATA_W-1:0] fillData_q;
    logic [WAY_W-1:0]  hitWay_q;
    logic              hitValid_q;
    logic              missDetect;
    logic              hitDetect;
    logic              timeoutHit;

    assign hitDetect  = (state_q == IDLE) && PrRd && Hit;
    assign missDetect = (state_q == IDLE) && PrRd && !Hit;

`ifdef IL1_FILL_TIMEOUT_EN
    logic timerExpired;

    il1_bus_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_bus_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (state_q == ISSUE),
        .enable_i  (state_q == WAIT),
        .expired_o (timerExpired)
    );

    assign timeoutHit = timerExpired && (state_q == WAIT);
`else
    assign timeoutHit = 1'b0;
`endif

    // State register plus the miss context. The victim way is captured only
    // at miss detection so later LRU updates cannot redirect the fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            missAddr_q  <= '0;
            victimWay_q <= '0;
            fillData_q  <= '0;
            hitWay_q    <= '0;
            hitValid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hitValid_q <= hitDetect;
            if (hitDetect) begin
                hitWay_q <= Hit_way;
            end
            if (missDetect) begin
                missAddr_q  <= Address;
                victimWay_q <= LRU_replacement_proc;
            end
            if ((state_q == WAIT) && Data_valid_Com) begin
                fillData_q <= Data_Bus_Com;
            end
        end
    end

    // Next-state logic. Grant and data-valid are only looked at in the state
    // that expects them; data arriving on the timeout cycle takes priority.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (missDetect) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (Bus_grant) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (Data_valid_Com) begin
                    state_d = FILL;
                end else if (timeoutHit) begin
                    state_d = REQ;
                end
            end
            FILL: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode directly from state so an asynchronous reset clears
    // every strobe in the same instant.
    always_comb begin
        CPU_stall        = missDetect || ((state_q != IDLE) && (state_q != DONE));
        Bus_req          = (state_q == REQ) || (state_q == ISSUE) || (state_q == WAIT);
        BusRd            = (state_q == ISSUE);
        Address_Com_out  = (state_q == ISSUE) ? missAddr_q : '0;
        Fill_en          = (state_q == FILL);
        Fill_way         = victimWay_q;
        Fill_addr        = missAddr_q;
        Fill_data        = fillData_q;
        Blk_access_valid = hitValid_q || (state_q == DONE);
        Blk_accessed     = (state_q == DONE) ? victimWay_q : hitWay_q;
        Fill_err         = timeoutHit && !Data_valid_Com;
    end

endmodule : il1_fill_controller

// File: tb/tb_il1_fill_controller.sv
// ----------------------------------------------------------------------------
// tb_il1_fill_controller
// Directed bench for il1_fill_controller: hit path, miss/fill timing, delayed
// grant with an LRU change, spurious data-valid, asynchronous reset mid-miss
// and (when IL1_FILL_TIMEOUT_EN is defined) the WAIT timeout with re-issue.
// ----------------------------------------------------------------------------
module tb_il1_fill_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        PrRd;
    logic [31:0] Address;
    logic        Hit;
    logic [1:0]  Hit_way;
    logic [1:0]  LRU_replacement_proc;
    logic        CPU_stall;
    logic        Bus_req;
    logic        Bus_grant;
    logic        BusRd;
    logic [31:0] Address_Com_out;
    logic [31:0] Data_Bus_Com;
    logic        Data_valid_Com;
    logic        Fill_en;
    logic [1:0]  Fill_way;
    logic [31:0] Fill_addr;
    logic [31:0] Fill_data;
    logic [1:0]  Blk_accessed;
    logic        Blk_access_valid;
    logic        Fill_err;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;
    int stallCycles;

    il1_fill_controller #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .WAY_W          (2),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .PrRd                 (PrRd),
        .Address              (Address),
        .Hit                  (Hit),
        .Hit_way              (Hit_way),
        .LRU_replacement_proc (LRU_replacement_proc),
        .CPU_stall            (CPU_stall),
        .Bus_req              (Bus_req),
        .Bus_grant            (Bus_grant),
        .BusRd                (BusRd),
        .Address_Com_out      (Address_Com_out),
        .Data_Bus_Com         (Data_Bus_Com),
        .Data_valid_Com       (Data_valid_Com),
        .Fill_en              (Fill_en),
        .Fill_way             (Fill_way),
        .Fill_addr            (Fill_addr),
        .Fill_data            (Fill_data),
        .Blk_accessed         (Blk_accessed),
        .Blk_access_valid     (Blk_access_valid),
        .Fill_err             (Fill_err)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Drive every DUT input for the current cycle, then let the
    // combinational outputs settle before any check.
    task automatic applyStimulus(input logic prRd, input logic hit, input logic [1:0] hitWay,
                                 input logic [1:0] lru, input logic [31:0] addr,
                                 input logic grant, input logic dv, input logic [31:0] data);
        PrRd                 = prRd;
        Hit                  = hit;
        Hit_way              = hitWay;
        LRU_replacement_proc = lru;
        Address              = addr;
        Bus_grant            = grant;
        Data_valid_Com       = dv;
        Data_Bus_Com         = data;
        #1;
    endtask

    // One comparison: counts it and reports a failure with tag and values.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(0, 0, 2'd0, 2'd0, 32'h0, 0, 0, 32'h0);
        #2;

        // Reset state.
        checkOutput("reset bus_req", Bus_req, 0);
        checkOutput("reset stall", CPU_stall, 0);
        checkOutput("reset fill_en", Fill_en, 0);
        checkOutput("reset blk_valid", Blk_access_valid, 0);
        checkOutput("reset fill_err", Fill_err, 0);
        #9 rst_n = 1'b1;

        // Hit on way 2: reported one cycle later, no stall, no bus traffic.
        $display("[TB] hit sequence");
        nextCycle();
        applyStimulus(1, 1, 2'd2, 2'd0, 32'h0000_0100, 0, 0, 32'h0);
        checkOutput("hit stall", CPU_stall, 0);
        checkOutput("hit bus_req", Bus_req, 0);
        checkOutput("hit valid early", Blk_access_valid, 0);
        nextCycle();
        checkOutput("hit valid", Blk_access_valid, 1);
        checkOutput("hit way", Blk_accessed, 2);
        checkOutput("hit stall next", CPU_stall, 0);
        applyStimulus(0, 0, 2'd0, 2'd0, 32'h0, 0, 0, 32'h0);
        nextCycle();
        checkOutput("hit valid drop", Blk_access_valid, 0);

        // Miss at 0x1040, victim 3, grant immediate, data after L=4.
        $display("[TB] miss sequence");
        stallCycles = 0;
        applyStimulus(1, 0, 2'd0, 2'd3, 32'h0000_1040, 1, 0, 32'h0);
        checkOutput("miss stall detect", CPU_stall, 1);
        stallCycles += int'(CPU_stall);
        nextCycle();
        checkOutput("miss req bus_req", Bus_req, 1);
        checkOutput("miss req busrd", BusRd, 0);
        stallCycles += int'(CPU_stall);
        nextCycle();
        applyStimulus(1, 0, 2'd0, 2'd3, 32'h0000_1040, 0, 0, 32'h0);
        checkOutput("miss busrd", BusRd, 1);
        checkOutput("miss com addr", Address_Com_out, 32'h0000_1040);
        checkOutput("miss issue bus_req", Bus_req, 1);
        stallCycles += int'(CPU_stall);
        for (int c = 3; c <= 5; c++) begin
            nextCycle();
            checkOutput("miss wait busrd", BusRd, 0);
            checkOutput("miss wait fill_en", Fill_en, 0);
            stallCycles += int'(CPU_stall);
        end
        nextCycle();
        applyStimulus(1, 0, 2'd0, 2'd3, 32'h0000_1040, 0, 1, 32'hDEAD_BEEF);
        checkOutput("miss data bus_req", Bus_req, 1);
        stallCycles += int'(CPU_stall);
        nextCycle();
        applyStimulus(1, 0, 2'd0, 2'd3, 32'h0000_1040, 0, 0, 32'h0);
        checkOutput("miss fill_en", Fill_en, 1);
        checkOutput("miss fill_way", Fill_way, 3);
        checkOutput("miss fill_addr", Fill_addr, 32'h0000_1040);
        checkOutput("miss fill_data", Fill_data, 32'hDEAD_BEEF);
        checkOutput("miss fill bus_req", Bus_req, 0);
        stallCycles += int'(CPU_stall);
        nextCycle();
        applyStimulus(1, 1, 2'd3, 2'd3, 32'h0000_1040, 0, 0, 32'h0);
        checkOutput("miss done fill_en", Fill_en, 0);
        checkOutput("miss done valid", Blk_access_valid, 1);
        checkOutput("miss done way", Blk_accessed, 3);
        checkOutput("miss done stall", CPU_stall, 0);
        stallCycles += int'(CPU_stall);
        checkOutput("miss stall cycles", stallCycles, 8);
        nextCycle();
        checkOutput("miss rehit idle valid", Blk_access_valid, 0);
        nextCycle();
        checkOutput("miss rehit valid", Blk_access_valid, 1);
        checkOutput("miss rehit way", Blk_accessed, 3);
        applyStimulus(0, 0, 2'd0, 2'd0, 32'h0, 0, 0, 32'h0);

        // Delayed grant, LRU changing mid-REQ, PrRd dropped mid-miss.
        $display("[TB] delayed grant sequence");
        nextCycle();
        applyStimulus(1, 0, 2'd0, 2'd3, 32'h0000_2080, 0, 0, 32'h0);
        for (int c = 1; c <= 5; c++) begin
            nextCycle();
            applyStimulus(0, 0, 2'd0, (c >= 2) ? 2'd1 : 2'd3, 32'h0, 0, 0, 32'h0);
            checkOutput("dgrant bus_req", Bus_req, 1);
            checkOutput("dgrant busrd", BusRd, 0);
            checkOutput("dgrant stall", CPU_stall, 1);
        end
        nextCycle();
        applyStimulus(0, 0, 2'd0, 2'd1, 32'h0, 1, 0, 32'h0);
        checkOutput("dgrant req busrd", BusRd, 0);
        nextCycle();
        applyStimulus(0, 0, 2'd0, 2'd1, 32'h0, 0, 0, 32'h0);
        checkOutput("dgrant busrd", BusRd, 1);
        checkOutput("dgrant com addr", Address_Com_out, 32'h0000_2080);
        nextCycle();
        applyStimulus(0, 0, 2'd0, 2'd1, 32'h0, 0, 1, 32'h1234_5678);
        nextCycle();
        applyStimulus(0, 0, 2'd0, 2'd1, 32'h0, 0, 0, 32'h0);
        checkOutput("dgrant fill_en", Fill_en, 1);
        checkOutput("dgrant fill_way", Fill_way, 3);
        checkOutput("dgrant fill_addr", Fill_addr, 32'h0000_2080);
        checkOutput("dgrant fill_data", Fill_data, 32'h1234_5678);
        nextCycle();
        checkOutput("dgrant done way", Blk_accessed, 3);
        checkOutput("dgrant done valid", Blk_access_valid, 1);

        // Spurious data-valid in IDLE and REQ, then reset during WAIT.
        $display("[TB] spurious and reset sequence");
        nextCycle();
        applyStimulus(0, 0, 2'd0, 2'd0, 32'h0, 0, 1, 32'hAAAA_5555);
        nextCycle();
        applyStimulus(1, 0, 2'd0, 2'd2, 32'h0000_40C0, 0, 0, 32'h0);
        checkOutput("spur idle fill_en", Fill_en, 0);
        nextCycle();
        applyStimulus(0, 0, 2'd0, 2'd2, 32'h0, 0, 1, 32'hAAAA_5555);
        checkOutput("spur req bus_req", Bus_req, 1);
        nextCycle();
        applyStimulus(0, 0, 2'd0, 2'd2, 32'h0, 1, 0, 32'h0);
        checkOutput("spur req fill_en", Fill_en, 0);
        checkOutput("spur req stays", BusRd, 0);
        nextCycle();
        applyStimulus(0, 0, 2'd0, 2'd2, 32'h0, 0, 0, 32'h0);
        checkOutput("rst issue busrd", BusRd, 1);
        nextCycle();
        checkOutput("rst wait bus_req", Bus_req, 1);
        checkOutput("rst wait fill_way", Fill_way, 2);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst async bus_req", Bus_req, 0);
        checkOutput("rst async stall", CPU_stall, 0);
        checkOutput("rst async fill_way", Fill_way, 0);
        checkOutput("rst async fill_addr", Fill_addr, 0);
        checkOutput("rst async blk", Blk_accessed, 0);
        #3 rst_n = 1'b1;
        nextCycle();
        applyStimulus(0, 0, 2'd0, 2'd0, 32'h0, 0, 1, 32'hBBBB_CCCC);
        nextCycle();
        applyStimulus(0, 0, 2'd0, 2'd0, 32'h0, 0, 0, 32'h0);
        checkOutput("rst late fill_en", Fill_en, 0);
        checkOutput("rst late bus_req", Bus_req, 0);
        checkOutput("rst late fill_data", Fill_data, 0);

`ifdef IL1_FILL_TIMEOUT_EN
        // No data for 10 WAIT cycles: Fill_err pulse, BusRd re-issued.
        $display("[TB] timeout sequence");
        nextCycle();
        applyStimulus(1, 0, 2'd0, 2'd2, 32'h0000_3000, 1, 0, 32'h0);
        nextCycle();
        nextCycle();
        checkOutput("tmo first busrd", BusRd, 1);
        for (int c = 1; c <= 9; c++) begin
            nextCycle();
            checkOutput("tmo wait no err", Fill_err, 0);
        end
        nextCycle();
        checkOutput("tmo err pulse", Fill_err, 1);
        nextCycle();
        checkOutput("tmo err drop", Fill_err, 0);
        checkOutput("tmo req bus_req", Bus_req, 1);
        nextCycle();
        applyStimulus(0, 0, 2'd0, 2'd0, 32'h0, 0, 0, 32'h0);
        checkOutput("tmo second busrd", BusRd, 1);
        checkOutput("tmo second addr", Address_Com_out, 32'h0000_3000);
        nextCycle();
        applyStimulus(0, 0, 2'd0, 2'd0, 32'h0, 0, 1, 32'hCAFE_F00D);
        nextCycle();
        applyStimulus(0, 0, 2'd0, 2'd0, 32'h0, 0, 0, 32'h0);
        checkOutput("tmo fill_en", Fill_en, 1);
        checkOutput("tmo fill_way", Fill_way, 2);
        checkOutput("tmo fill_data", Fill_data, 32'hCAFE_F00D);
        nextCycle();
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule : tb_il1_fill_controller
